// File: rtl/patch_reducer_dispatcher_if.sv
// Configuration and result channels of the patch reducer dispatcher.
// The dispatcher sits on the slave side; the config-fetch and result-writer logic sits on the master side.
interface patch_reducer_dispatcher_if #(
  parameter int APP_DATA_WIDTH = 256,
  parameter int FP_SIZE        = 32,
  parameter int IDX_W          = 3
);
  logic                      cfg_valid;
  logic [1:0]                cfg_topbtm;
  logic [APP_DATA_WIDTH-1:0] cfg_data;
  logic                      cfg_ready;

  logic                      out_valid;
  logic [FP_SIZE-1:0]        out_sum;
  logic [IDX_W-1:0]          out_reducer;
  logic [1:0]                out_code;
  logic                      out_ready;

  modport master (
    output cfg_valid, cfg_topbtm, cfg_data, out_ready,
    input  cfg_ready, out_valid, out_sum, out_reducer, out_code
  );

  modport slave (
    input  cfg_valid, cfg_topbtm, cfg_data, out_ready,
    output cfg_ready, out_valid, out_sum, out_reducer, out_code
  );
endinterface

// File: rtl/patch_reducer_dispatcher.sv
// Dispatches config words to the lowest idle patch row reducer, captures each reducer's
// one-cycle sum pulse and drains captured sums round-robin through one valid/ready port.
module patch_reducer_dispatcher #(
  parameter int N_PATCH_REDUCER = 8,
  parameter int APP_DATA_WIDTH  = 256,
  parameter int FP_SIZE         = 32,
  localparam int IDX_W          = $clog2(N_PATCH_REDUCER),
  localparam int CNT_W          = IDX_W + 1
) (
  input  logic                               reset,
  input  logic                               dram_clk,
  patch_reducer_dispatcher_if.slave          bus,
  output logic [2*N_PATCH_REDUCER-1:0]       red_init,
  output logic [APP_DATA_WIDTH-1:0]          red_config_data,
  input  logic [2*N_PATCH_REDUCER-1:0]       red_sum_rdy,
  input  logic [FP_SIZE*N_PATCH_REDUCER-1:0] red_sum,
  output logic [CNT_W-1:0]                   n_busy,
  output logic                               proto_err
);

  logic [N_PATCH_REDUCER-1:0]   busy, busy_next;
  logic [N_PATCH_REDUCER-1:0]   cap_v, cap_set;
  logic [FP_SIZE-1:0]           cap_sum  [N_PATCH_REDUCER];
  logic [1:0]                   cap_code [N_PATCH_REDUCER];
  logic [IDX_W-1:0]             rr_ptr;

  logic                         free_any;
  logic [IDX_W-1:0]             free_idx;
  logic                         cfg_take, dispatch, cfg_bad, pulse_bad;
  logic                         gnt_any, gnt_fire, out_load, handshake;
  logic [IDX_W-1:0]             gnt_idx, probe;
  logic [2*N_PATCH_REDUCER-1:0] init_next;
  logic [APP_DATA_WIDTH-1:0]    cfg_word;
  logic [CNT_W-1:0]             busy_cnt;

  always_comb begin : dispatch_select
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < N_PATCH_REDUCER; i++) begin
      if (!busy[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign bus.cfg_ready = !reset && free_any;
  assign cfg_take      = bus.cfg_valid && bus.cfg_ready;
  assign dispatch      = cfg_take && (bus.cfg_topbtm != 2'b00);
  assign cfg_bad       = cfg_take && (bus.cfg_topbtm == 2'b00);

  // A pulse is captured only by a busy reducer with an empty slot; anything else is a protocol error.
  always_comb begin : capture_select
    cap_set   = '0;
    pulse_bad = 1'b0;
    for (int unsigned i = 0; i < N_PATCH_REDUCER; i++) begin
      if (red_sum_rdy[2*i +: 2] != 2'b00) begin
        if (busy[i] && !cap_v[i]) cap_set[i] = 1'b1;
        else                      pulse_bad  = 1'b1;
      end
    end
  end

  // Round-robin search; index arithmetic wraps because N is a power of two.
  always_comb begin : grant_select
    gnt_any = 1'b0;
    gnt_idx = '0;
    probe   = '0;
    for (int unsigned j = 0; j < N_PATCH_REDUCER; j++) begin
      probe = rr_ptr + IDX_W'(j);
      if (cap_v[probe] && !gnt_any) begin
        gnt_any = 1'b1;
        gnt_idx = probe;
      end
    end
  end

  assign out_load  = !bus.out_valid || bus.out_ready;
  assign gnt_fire  = out_load && gnt_any;
  assign handshake = bus.out_valid && bus.out_ready;

  always_comb begin : busy_update
    busy_next = busy;
    init_next = '0;
    busy_cnt  = '0;
    cfg_word  = bus.cfg_data;
    cfg_word[IDX_W-1:0] = free_idx;
    for (int unsigned i = 0; i < N_PATCH_REDUCER; i++) begin
      if (handshake && bus.out_reducer == IDX_W'(i)) busy_next[i] = 1'b0;
      if (dispatch && free_idx == IDX_W'(i)) begin
        busy_next[i]        = 1'b1;
        init_next[2*i +: 2] = bus.cfg_topbtm;
      end
    end
    for (int unsigned i = 0; i < N_PATCH_REDUCER; i++) begin
      busy_cnt = busy_cnt + CNT_W'(busy_next[i]);
    end
  end

  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      busy            <= '0;
      cap_v           <= '0;
      rr_ptr          <= '0;
      n_busy          <= '0;
      proto_err       <= 1'b0;
      red_init        <= '0;
      red_config_data <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_sum     <= '0;
      bus.out_reducer <= '0;
      bus.out_code    <= '0;
      for (int unsigned i = 0; i < N_PATCH_REDUCER; i++) begin
        cap_sum[i]  <= '0;
        cap_code[i] <= '0;
      end
    end else begin
      busy     <= busy_next;
      n_busy   <= busy_cnt;
      red_init <= init_next;
      if (dispatch) red_config_data <= cfg_word;
      if (cfg_bad || pulse_bad) proto_err <= 1'b1;
      for (int unsigned i = 0; i < N_PATCH_REDUCER; i++) begin
        if (cap_set[i]) begin
          cap_v[i]    <= 1'b1;
          cap_sum[i]  <= red_sum[FP_SIZE*i +: FP_SIZE];
          cap_code[i] <= red_sum_rdy[2*i +: 2];
        end else if (gnt_fire && gnt_idx == IDX_W'(i)) begin
          cap_v[i] <= 1'b0;
        end
      end
      if (out_load) begin
        bus.out_valid <= gnt_any;
        if (gnt_any) begin
          bus.out_sum     <= cap_sum[gnt_idx];
          bus.out_reducer <= gnt_idx;
          bus.out_code    <= cap_code[gnt_idx];
          rr_ptr          <= gnt_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_patch_reducer_dispatcher.sv
// Randomized and directed bench for patch_reducer_dispatcher against a cycle-level behavioural model.
module tb_patch_reducer_dispatcher;
  localparam int N  = 8;
  localparam int W  = 256;
  localparam int FP = 32;
  localparam int IW = 3;

  logic              reset;
  logic              dram_clk;
  logic [2*N-1:0]    red_init;
  logic [W-1:0]      red_config_data;
  logic [2*N-1:0]    red_sum_rdy;
  logic [FP*N-1:0]   red_sum;
  logic [IW:0]       n_busy;
  logic              proto_err;

  patch_reducer_dispatcher_if #(.APP_DATA_WIDTH(W), .FP_SIZE(FP), .IDX_W(IW)) bus ();

  patch_reducer_dispatcher #(
    .N_PATCH_REDUCER(N),
    .APP_DATA_WIDTH (W),
    .FP_SIZE        (FP)
  ) dut (
    .reset          (reset),
    .dram_clk       (dram_clk),
    .bus            (bus),
    .red_init       (red_init),
    .red_config_data(red_config_data),
    .red_sum_rdy    (red_sum_rdy),
    .red_sum        (red_sum),
    .n_busy         (n_busy),
    .proto_err      (proto_err)
  );

  initial dram_clk = 1'b0;
  always #5 dram_clk = ~dram_clk;

  int tests = 0;
  int fails = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: reducer pool seen as sets of busy/captured reducers.
  bit   [N-1:0]  m_busy, m_capv, pulsed;
  logic [31:0]   m_capsum  [N];
  logic [1:0]    m_capcode [N];
  int            m_rr, m_ored;
  bit            m_ov, m_perr;
  logic [31:0]   m_osum;
  logic [1:0]    m_ocode;
  logic [2*N-1:0] m_init;
  logic [W-1:0]  m_cfgd;
  int            hs_log [$];

  function automatic int m_free_idx();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_capv = '0; pulsed = '0;
    m_rr = 0; m_ored = 0; m_ov = 0; m_perr = 0;
    m_osum = '0; m_ocode = '0; m_init = '0; m_cfgd = '0;
    for (int i = 0; i < N; i++) begin m_capsum[i] = '0; m_capcode[i] = '0; end
  endtask

  task automatic check_outputs();
    check_val("cfg_ready", bus.cfg_ready, (!reset && m_free_idx() >= 0));
    check_val("out_valid", bus.out_valid, m_ov);
    check_val("out_sum", bus.out_sum, m_osum);
    check_val("out_reducer", bus.out_reducer, m_ored);
    check_val("out_code", bus.out_code, m_ocode);
    check_val("red_init", red_init, m_init);
    check_val("red_config_data", red_config_data, m_cfgd);
    check_val("n_busy", n_busy, $countones(m_busy));
    check_val("proto_err", proto_err, m_perr);
  endtask

  // Advance the model across one clock edge from the pre-edge state and inputs.
  task automatic model_step();
    bit [N-1:0] nb, nc;
    int k, g, c;
    if (reset) return;
    nb = m_busy; nc = m_capv;
    k = m_free_idx();
    m_init = '0;
    if (bus.cfg_valid && k >= 0) begin
      if (bus.cfg_topbtm == 2'b00) m_perr = 1;
      else begin
        nb[k] = 1;
        pulsed[k] = 0;
        m_init[2*k +: 2] = bus.cfg_topbtm;
        m_cfgd = bus.cfg_data;
        m_cfgd[IW-1:0] = k[IW-1:0];
      end
    end
    if (m_ov && bus.out_ready) nb[m_ored] = 0;
    if (!m_ov || bus.out_ready) begin
      g = -1;
      for (int j = 0; j < N; j++) begin
        c = (m_rr + j) % N;
        if (g < 0 && m_capv[c]) g = c;
      end
      m_ov = (g >= 0);
      if (g >= 0) begin
        m_osum = m_capsum[g]; m_ocode = m_capcode[g]; m_ored = g;
        nc[g] = 0; m_rr = (g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (red_sum_rdy[2*i +: 2] != 2'b00) begin
        if (m_busy[i] && !m_capv[i]) begin
          nc[i] = 1;
          m_capsum[i]  = red_sum[FP*i +: FP];
          m_capcode[i] = red_sum_rdy[2*i +: 2];
        end else m_perr = 1;
      end
    end
    m_busy = nb; m_capv = nc;
  endtask

  task automatic tick();
    @(negedge dram_clk);
    check_outputs();
    if (bus.out_valid && bus.out_ready) hs_log.push_back(int'(bus.out_reducer));
    @(posedge dram_clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_valid = 0; bus.cfg_topbtm = 2'b00; bus.cfg_data = '0;
    red_sum_rdy = '0; red_sum = '0;
  endtask

  task automatic send_cfg(input logic [1:0] tb_code);
    bus.cfg_valid = 1; bus.cfg_topbtm = tb_code;
    bus.cfg_data = {8{$urandom}};
    tick();
    bus.cfg_valid = 0;
  endtask

  task automatic set_pulse(input int i, input logic [1:0] code, input logic [31:0] sum);
    red_sum_rdy[2*i +: 2] = code;
    red_sum[FP*i +: FP] = sum;
    pulsed[i] = 1;
  endtask

  task automatic do_reset();
    reset = 1; #1;
    model_reset();
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_cfg_ready", bus.cfg_ready, 0);
    check_val("rst_red_init", red_init, 0);
    check_val("rst_n_busy", n_busy, 0);
    check_val("rst_out_sum", bus.out_sum, 0);
    idle_inputs();
    tick(); tick();
    reset = 0;
  endtask

  int exp_busy;

  initial begin
    idle_inputs();
    bus.out_ready = 1;
    reset = 0;
    model_reset();
    #2 do_reset();

    // Eight back-to-back dispatches fill the pool in index order.
    for (int i = 0; i < N; i++) send_cfg(2'b11);
    check_val("full_n_busy", n_busy, 8);
    check_val("full_cfg_ready", bus.cfg_ready, 0);
    tick();

    // Single result from reducer 3, then its slot is reused.
    set_pulse(3, 2'd2, 32'h3F80_0000);
    tick();
    red_sum_rdy = '0;
    repeat (3) tick();
    send_cfg(2'b01);
    check_val("reuse_red3", red_init, 16'h0040);

    // Reducer 4 alone moves the pointer to 5, then 1/4/6 fire together.
    set_pulse(4, 2'd1, 32'h0000_1234);
    tick();
    red_sum_rdy = '0;
    repeat (3) tick();
    send_cfg(2'b10);
    hs_log.delete();
    set_pulse(1, 2'd1, 32'hAAAA_0001);
    set_pulse(4, 2'd2, 32'hAAAA_0004);
    set_pulse(6, 2'd1, 32'hAAAA_0006);
    tick();
    red_sum_rdy = '0;
    repeat (6) tick();
    check_val("rr_count", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      check_val("rr_first", hs_log[0], 6);
      check_val("rr_second", hs_log[1], 1);
      check_val("rr_third", hs_log[2], 4);
    end

    // Back-pressure: three captures held for ten cycles, then drained.
    send_cfg(2'b11); send_cfg(2'b11); send_cfg(2'b11);
    bus.out_ready = 0;
    set_pulse(1, 2'd2, 32'hBEEF_0001); tick(); red_sum_rdy = '0;
    set_pulse(4, 2'd1, 32'hBEEF_0004); tick(); red_sum_rdy = '0;
    set_pulse(6, 2'd2, 32'hBEEF_0006); tick(); red_sum_rdy = '0;
    repeat (10) tick();
    exp_busy = $countones(m_busy) - 3;
    bus.out_ready = 1;
    repeat (5) tick();
    check_val("drain_n_busy", n_busy, exp_busy);

    // Randomized traffic with well-behaved reducers.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.cfg_valid  = ($urandom_range(0, 1) == 1);
      bus.cfg_topbtm = 2'($urandom_range(1, 3));
      bus.cfg_data   = {8{$urandom}};
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      red_sum_rdy = '0;
      red_sum = {8{$urandom}};
      for (int i = 0; i < N; i++)
        if (m_busy[i] && !pulsed[i] && $urandom_range(0, 3) == 0)
          set_pulse(i, 2'($urandom_range(1, 2)), $urandom);
      tick();
    end
    idle_inputs();
    bus.out_ready = 1;
    repeat (12) tick();
    check_val("rand_no_err", proto_err, 0);

    // Reset mid-drain with four busy reducers.
    do_reset();
    for (int i = 0; i < 4; i++) send_cfg(2'b11);
    for (int i = 0; i < 4; i++) set_pulse(i, 2'd1, 32'hC0DE_0000 + i);
    tick();
    red_sum_rdy = '0;
    repeat (2) tick();
    do_reset();
    send_cfg(2'b10);
    check_val("restart_red0", red_init, 16'h0002);
    repeat (2) tick();

    // Protocol errors: pulse on an idle reducer, then an empty config code.
    do_reset();
    set_pulse(2, 2'd1, 32'h1111_2222);
    tick();
    red_sum_rdy = '0;
    repeat (3) tick();
    check_val("idle_pulse_err", proto_err, 1);
    check_val("idle_pulse_noout", bus.out_valid, 0);
    do_reset();
    send_cfg(2'b00);
    repeat (2) tick();
    check_val("zero_cfg_err", proto_err, 1);
    check_val("zero_cfg_busy", n_busy, 0);
    check_val("zero_cfg_init", red_init, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
